param_data_memory: RTL and testbench
====================================

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 32, number of words; need not be a power of 2.
REQ-003 SHALL have parameter ADDR_W, default 5, address width; 2**ADDR_W >= DEPTH.
REQ-004 SHALL have parameter INIT_CLEAR, default 1; 1 = zero-clear the array after reset.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port wr  in  1  write request.
REQ-008 SHALL have port rd  in  1  read request.
REQ-009 SHALL have port address  in  ADDR_W  word address shared by rd and wr.
REQ-010 SHALL have port data_write  in  DATA_W  write data.
REQ-011 SHALL have port lane_en  in  DATA_W/8  per-byte write enable; bit i gates bits [8i+7:8i].
REQ-012 SHALL have port data_read  out  DATA_W  registered read data.
REQ-013 SHALL have port rd_valid  out  1  one-cycle pulse; data_read is valid.
REQ-014 SHALL have port ready  out  1  block accepts requests.
REQ-015 SHALL have port err  out  1  one-cycle pulse; request addressed >= DEPTH.

Function
REQ-016 SHALL implement FSM states INIT and RUN; rst forces INIT.
REQ-017 INIT with INIT_CLEAR=1: SHALL write zero to word clr_cnt each cycle, clr_cnt 0..DEPTH-1, then enter RUN; ready=0 throughout (DEPTH cycles).
REQ-018 INIT with INIT_CLEAR=0: SHALL enter RUN on the first clock edge after rst deasserts; array contents undefined.
REQ-019 ready SHALL be 1 exactly when state is RUN.
REQ-020 rd/wr while ready=0 SHALL be ignored: no array write, no rd_valid, no err.
REQ-021 Write in RUN: SHALL update only the lanes with lane_en=1 at address on the clock edge; lane_en=0 leaves the write with no effect.
REQ-022 Read in RUN: SHALL present array[address] on data_read with rd_valid=1 in the cycle after rd is sampled (latency 1).
REQ-023 Simultaneous rd and wr to the same address SHALL be write-first: data_read = old word merged with enabled lanes of data_write.
REQ-024 Simultaneous rd and wr to different addresses SHALL both complete in the same cycle.
REQ-025 data_read SHALL hold its last value when no read completes; rd_valid=0 in those cycles.
REQ-026 address >= DEPTH: write SHALL be dropped; a read SHALL return data_read=0 with rd_valid=1; err=1 the next cycle for either request.
REQ-027 Back-to-back reads SHALL sustain one result per cycle.

Reset
REQ-028 On rst: state=INIT, clr_cnt=0, data_read=0, rd_valid=0, err=0, ready=0, immediately and asynchronously.
REQ-029 rst asserted mid-INIT or mid-RUN SHALL abort any in-flight read (no rd_valid) and restart INIT from clr_cnt=0.
REQ-030 Array contents SHALL be reset only via the INIT clear sequence, not asynchronously.

Structure
REQ-031 State encoding (INIT, RUN) and the lane-width constant 8 SHALL live in a shared package, e.g. mem_pkg.
REQ-032 Lane merge (old word, new word, lane_en -> merged word) SHALL be one sub-module, lane_merge, reused for write and write-first forwarding.
REQ-033 Array SHALL be a single register array DEPTH x DATA_W; no vendor macros.

Verification
REQ-034 Defaults, INIT_CLEAR=1: release rst -> ready low 32 cycles, then high; read addresses 0..31 -> all 0x00, rd_valid one cycle after each rd.
REQ-035 DATA_W=32: write 0xAABBCCDD addr 3 lane_en=1111, then 0x11223344 lane_en=0101 -> read addr 3 returns 0xAA22CC44.
REQ-036 Same-cycle rd+wr addr 7, old 0x0F, new 0xF0, lane_en=1 -> next cycle data_read=0xF0, rd_valid=1; later read returns 0xF0.
REQ-037 DEPTH=20, ADDR_W=5: write 0x55 addr 25, read addr 25 -> data_read=0x00, rd_valid=1, err=1; addr 5 (25 mod 20) unchanged.
REQ-038 Assert rst at cycle 10 of INIT and while rd pending in RUN -> rd_valid stays 0, ready=0, full 32-cycle clear restarts.
REQ-039 Issue rd/wr while ready=0 -> no array change, rd_valid=0, err=0.

Source files
------------

// File: rtl/param_data_memory_pkg.sv
// Shared definitions for param_data_memory: controller state encoding and byte-lane width.
// Pure declarations, no logic.
package param_data_memory_pkg;

  localparam int LANE_W = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/lane_merge.sv
// Byte-lane merge: each lane comes from new_i when its enable is set, otherwise from old_i.
// Purely combinational, zero latency, no flow control.
module lane_merge
  import param_data_memory_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]        old_i,
  input  logic [DATA_W-1:0]        new_i,
  input  logic [DATA_W/LANE_W-1:0] lane_en_i,
  output logic [DATA_W-1:0]        merged_o
);

  for (genvar i = 0; i < DATA_W / LANE_W; i++) begin : g_lane
    assign merged_o[i*LANE_W +: LANE_W] = lane_en_i[i] ? new_i[i*LANE_W +: LANE_W]
                                                       : old_i[i*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/param_data_memory.sv
// Single-port register-array memory with byte lanes, write-first read forwarding and a post-reset clear sweep.
// Read latency 1 cycle, one result per cycle; requests are dropped while ready is low (clear sweep).
module param_data_memory
  import param_data_memory_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int          ADDR_W     = 5,
  parameter int          INIT_CLEAR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        data_write,
  input  logic [DATA_W/LANE_W-1:0] lane_en,
  output logic [DATA_W-1:0]        data_read,
  output logic                     rd_valid,
  output logic                     ready,
  output logic                     err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   data_read_q, data_read_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                in_range;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged_word;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign in_range = {1'b0, address} < DEPTH_X;
  assign old_word = in_range ? mem_q[address] : '0;

  // One merge result feeds both the array write and the write-first read path.
  lane_merge #(
    .DATA_W (DATA_W)
  ) u_lane_merge (
    .old_i     (old_word),
    .new_i     (data_write),
    .lane_en_i (lane_en),
    .merged_o  (merged_word)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    data_read_d = data_read_q;
    rd_valid_d  = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = address;
    mem_wdata   = merged_word;

    case (state_q)
      ST_INIT: begin
        if (INIT_CLEAR != 0) begin
          mem_we    = 1'b1;
          mem_waddr = clr_cnt_q;
          mem_wdata = '0;
          if (clr_cnt_q == LAST_ADDR) begin
            state_d = ST_RUN;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we = wr && in_range;
        err_d  = (rd || wr) && !in_range;
        if (rd) begin
          rd_valid_d  = 1'b1;
          data_read_d = !in_range ? '0 : (wr ? merged_word : old_word);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      data_read_q <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      data_read_q <= data_read_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
    end
  end

  // The array is cleared only by the INIT sweep, never by rst itself.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign data_read = data_read_q;
  assign rd_valid  = rd_valid_q;
  assign err       = err_q;
  assign ready     = (state_q == ST_RUN);

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: a default (8-bit x 32) and a wide (32-bit x 20) instance share one stimulus stream
// and are checked every cycle against an array-based reference model.
module tb_param_data_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  address = '0;
  logic [31:0] data_write = '0;
  logic [3:0]  lane_en = '0;

  logic [7:0]  dr_n;
  logic        rdv_n, rdy_n, err_n;
  logic [31:0] dr_w;
  logic        rdv_w, rdy_w, err_w;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [2][32];
  int          init_left [2];
  logic [31:0] exp_dr [2];
  logic        exp_rdv [2];
  logic        exp_err [2];

  always #5 clk = ~clk;

  param_data_memory u_narrow (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .rd         (rd),
    .address    (address),
    .data_write (data_write[7:0]),
    .lane_en    (lane_en[0]),
    .data_read  (dr_n),
    .rd_valid   (rdv_n),
    .ready      (rdy_n),
    .err        (err_n)
  );

  param_data_memory #(
    .DATA_W     (32),
    .DEPTH      (20),
    .ADDR_W     (5),
    .INIT_CLEAR (1)
  ) u_wide (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .rd         (rd),
    .address    (address),
    .data_write (data_write),
    .lane_en    (lane_en),
    .data_read  (dr_w),
    .rd_valid   (rdv_w),
    .ready      (rdy_w),
    .err        (err_w)
  );

  function automatic int depth_of(int k);
    return (k == 0) ? 32 : 20;
  endfunction

  function automatic int lanes_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      init_left[k] = depth_of(k);
      exp_dr[k]    = '0;
      exp_rdv[k]   = 1'b0;
      exp_err[k]   = 1'b0;
    end
  endtask

  // Reference behaviour of one clock edge, from the sampled inputs.
  task automatic model_edge();
    int          d;
    logic [31:0] w;
    for (int k = 0; k < 2; k++) begin
      d = depth_of(k);
      if (rst) begin
        init_left[k] = d;
        exp_dr[k]    = '0;
        exp_rdv[k]   = 1'b0;
        exp_err[k]   = 1'b0;
      end else if (init_left[k] > 0) begin
        exp_rdv[k] = 1'b0;
        exp_err[k] = 1'b0;
        init_left[k]--;
        if (init_left[k] == 0) begin
          for (int a = 0; a < 32; a++) ref_mem[k][a] = '0;
        end
      end else begin
        exp_rdv[k] = rd;
        exp_err[k] = (rd || wr) && (int'(address) >= d);
        if (int'(address) < d) begin
          w = ref_mem[k][address];
          if (wr) begin
            for (int i = 0; i < lanes_of(k); i++) begin
              if (lane_en[i]) w[8*i +: 8] = data_write[8*i +: 8];
            end
            ref_mem[k][address] = w;
          end
          if (rd) exp_dr[k] = w;
        end else if (rd) begin
          exp_dr[k] = '0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("n_data_read", {24'h0, dr_n}, exp_dr[0]);
    chk("n_rd_valid",  32'(rdv_n), 32'(exp_rdv[0]));
    chk("n_err",       32'(err_n), 32'(exp_err[0]));
    chk("n_ready",     32'(rdy_n), 32'(init_left[0] == 0));
    chk("w_data_read", dr_w, exp_dr[1]);
    chk("w_rd_valid",  32'(rdv_w), 32'(exp_rdv[1]));
    chk("w_err",       32'(err_w), 32'(exp_err[1]));
    chk("w_ready",     32'(rdy_w), 32'(init_left[1] == 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic rand_req();
    rd         = 1'($urandom);
    wr         = 1'($urandom);
    address    = 5'($urandom);
    data_write = $urandom;
    lane_en    = 4'($urandom);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Requests keep arriving during the clear sweep; the model expects them to be ignored.
  task automatic wait_ready();
    int c  = 0;
    int cn = -1;
    int cw = -1;
    while ((cn < 0 || cw < 0) && c < 200) begin
      rand_req();
      step();
      c++;
      if (cn < 0 && rdy_n) cn = c;
      if (cw < 0 && rdy_w) cw = c;
    end
    idle();
    chk("n_init_cycles", cn, 32);
    chk("w_init_cycles", cw, 20);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    model_reset();
    reset_pulse();
    wait_ready();

    for (int a = 0; a < 32; a++) begin
      rd      = 1'b1;
      address = 5'(a);
      step();
    end
    idle();
    step();

    // Reset in the middle of the clear sweep restarts it from the beginning.
    reset_pulse();
    repeat (10) begin
      rand_req();
      step();
    end
    idle();
    reset_pulse();
    wait_ready();

    wr = 1'b1; address = 5'd3; data_write = 32'hAABBCCDD; lane_en = 4'hF;
    step();
    data_write = 32'h11223344; lane_en = 4'h5;
    step();
    wr = 1'b0; rd = 1'b1;
    step();
    chk("lane_merge_word", dr_w, 32'hAA22CC44);
    rd = 1'b0;
    step();
    chk("hold_no_read", dr_w, 32'hAA22CC44);

    wr = 1'b1; address = 5'd7; data_write = 32'h0F; lane_en = 4'h1;
    step();
    rd = 1'b1; data_write = 32'hF0;
    step();
    chk("write_first_data", {24'h0, dr_n}, 32'hF0);
    chk("write_first_valid", 32'(rdv_n), 32'd1);
    idle();
    step();
    rd = 1'b1;
    step();
    chk("write_first_later", {24'h0, dr_n}, 32'hF0);
    idle();

    wr = 1'b1; address = 5'd5; data_write = 32'h12345678; lane_en = 4'hF;
    step();
    address = 5'd25; data_write = 32'h55;
    step();
    chk("oor_write_err", 32'(err_w), 32'd1);
    wr = 1'b0; rd = 1'b1;
    step();
    chk("oor_read_data", dr_w, 32'h0);
    chk("oor_read_valid", 32'(rdv_w), 32'd1);
    chk("oor_read_err", 32'(err_w), 32'd1);
    address = 5'd5;
    step();
    chk("oor_no_alias", dr_w, 32'h12345678);
    idle();
    step();
    chk("err_single_pulse", 32'(err_w), 32'd0);

    // A read result on the bus is cleared at once when reset hits.
    rd = 1'b1; address = 5'd1;
    step();
    reset_pulse();
    chk("abort_rd_valid", 32'(rdv_n), 32'd0);
    idle();
    wait_ready();

    repeat (800) begin
      rand_req();
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
